// File: rtl/register_file_param_if.sv
// register_file_param_if: request/response bundle between the decode stage and the register file
interface register_file_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] addr_r1;
  logic [ADDR_WIDTH-1:0] addr_r2;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] data_w;
  logic [DATA_WIDTH-1:0] data_r1;
  logic [DATA_WIDTH-1:0] data_r2;
  logic                  rd_valid;
  logic                  busy;
  modport master (
    output read, write, addr_r1, addr_r2, addr_w, data_w,
    input  data_r1, data_r2, rd_valid, busy
  );
  modport slave (
    input  read, write, addr_r1, addr_r2, addr_w, data_w,
    output data_r1, data_r2, rd_valid, busy
  );
endinterface

// File: rtl/register_file_param.sv
// register_file_param: 2R/1W register file with hardware clear sequencer; define REGFILE_BYPASS_EN for write-through forwarding on read/write collisions
module register_file_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  register_file_param_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_WIDTH-1:0] data_r1_q, data_r1_d, data_r2_q, data_r2_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  we, rd_acc, wr_acc;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd, rd1, rd2;
  assign rd_acc = state_q == READY && bus.read;
  assign wr_acc = state_q == READY && bus.write && !(ZERO_REG && bus.addr_w == '0);
  // zero register wins over forwarding, forwarding wins over the stored value
  assign rd1 = (ZERO_REG && bus.addr_r1 == '0) ? '0 :
               (BYPASS && wr_acc && bus.addr_r1 == bus.addr_w) ? bus.data_w : mem_q[bus.addr_r1];
  assign rd2 = (ZERO_REG && bus.addr_r2 == '0) ? '0 :
               (BYPASS && wr_acc && bus.addr_r2 == bus.addr_w) ? bus.data_w : mem_q[bus.addr_r2];
  // next state: clear walks every entry once, then requests are served
  always_comb begin
    state_d    = (state_q == CLEAR && &clr_idx_q) ? READY : state_q;
    clr_idx_d  = (state_q == CLEAR) ? clr_idx_q + ADDR_WIDTH'(1) : clr_idx_q;
    data_r1_d  = rd_acc ? rd1 : data_r1_q;
    data_r2_d  = rd_acc ? rd2 : data_r2_q;
    rd_valid_d = rd_acc;
    we         = state_q == CLEAR || wr_acc;
    wa         = (state_q == CLEAR) ? clr_idx_q : bus.addr_w;
    wd         = (state_q == CLEAR) ? '0 : bus.data_w;
  end
  // control and read-output registers; reset restarts the clear sequence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      data_r1_q  <= '0;
      data_r2_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      data_r1_q  <= data_r1_d;
      data_r2_q  <= data_r2_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  // storage array, shared by the clear sequencer and the write port
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end
  assign bus.data_r1  = data_r1_q;
  assign bus.data_r2  = data_r2_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = state_q == CLEAR;
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: randomized self-checking bench for register_file_param against an array model
module tb_register_file_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;
  register_file_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  register_file_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) sbus ();
  register_file_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  register_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0)) dut_s (
    .clk(clk), .rst(rst_s), .bus(sbus)
  );
  int checks = 0;
  int passed = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_r1 = '0;
  logic [DW-1:0] exp_r2 = '0;
  logic          exp_v = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_rd(input int a, input bit wr, input int wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (BYP && wr && a == wa) return wd;
    return mem_m[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    exp_r1 = '0;
    exp_r2 = '0;
    exp_v = 1'b0;
  endtask

  // one accepted-phase cycle: drive, predict, clock, then commit write to model
  task automatic cycle(input bit rd, input int a1, input int a2, input bit wr, input int wa, input logic [DW-1:0] wd);
    bus.read = rd;
    bus.write = wr;
    bus.addr_r1 = a1[AW-1:0];
    bus.addr_r2 = a2[AW-1:0];
    bus.addr_w = wa[AW-1:0];
    bus.data_w = wd;
    if (rd) begin
      exp_r1 = model_rd(a1, wr, wa, wd);
      exp_r2 = model_rd(a2, wr, wa, wd);
    end
    exp_v = rd;
    step();
    if (wr && wa != 0) mem_m[wa] = wd;
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) $display("FAIL reset_flags busy=%b rd_valid=%b exp busy=1 rd_valid=0", bus.busy, bus.rd_valid); else passed++;
    checks++; if (bus.data_r1 !== '0 || bus.data_r2 !== '0) $display("FAIL reset_data r1=%h r2=%h exp 0", bus.data_r1, bus.data_r2); else passed++;
    rst = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      bus.read = 1'b1;
      bus.addr_r1 = AW'($urandom);
      step();
      cnt++;
      checks++; if (bus.rd_valid !== 1'b0) $display("FAIL clear_rd_valid cycle=%0d got=%b exp=0", cnt, bus.rd_valid); else passed++;
    end
    bus.read = 1'b0;
    checks++; if (cnt !== DEPTH) $display("FAIL clear_len got=%0d exp=%0d", cnt, DEPTH); else passed++;
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, i, int'($urandom_range(0, DEPTH-1)), 1'b0, 0, '0);
      checks++; if (bus.data_r1 !== exp_r1 || bus.data_r2 !== exp_r2 || bus.rd_valid !== 1'b1) $display("FAIL reset_read a=%0d r1=%h r2=%h v=%b exp %h %h 1", i, bus.data_r1, bus.data_r2, bus.rd_valid, exp_r1, exp_r2); else passed++;
    end
  endtask

  task automatic test_write_read();
    for (int i = 1; i < DEPTH; i++) begin
      cycle(1'b0, 0, 0, 1'b1, i, DW'(i));
      checks++; if (bus.rd_valid !== 1'b0) $display("FAIL write_rd_valid a=%0d got=%b exp=0", i, bus.rd_valid); else passed++;
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, i, DEPTH-1-i, 1'b0, 0, '0);
      checks++; if (bus.data_r1 !== DW'(i) || bus.data_r2 !== DW'(DEPTH-1-i) || bus.rd_valid !== 1'b1) $display("FAIL write_read i=%0d r1=%h r2=%h v=%b exp %h %h 1", i, bus.data_r1, bus.data_r2, bus.rd_valid, i, DEPTH-1-i); else passed++;
    end
  endtask

  task automatic test_zero_reg();
    cycle(1'b0, 0, 0, 1'b1, 0, 32'hDEADBEEF);
    cycle(1'b1, 0, 0, 1'b0, 0, '0);
    checks++; if (bus.data_r1 !== '0 || bus.data_r2 !== '0) $display("FAIL zero_read r1=%h r2=%h exp 0", bus.data_r1, bus.data_r2); else passed++;
    cycle(1'b1, 0, 3, 1'b1, 0, 32'hDEADBEEF);
    checks++; if (bus.data_r1 !== '0 || bus.data_r2 !== 32'h3) $display("FAIL zero_collide r1=%h r2=%h exp 0 3", bus.data_r1, bus.data_r2); else passed++;
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    cycle(1'b0, 0, 0, 1'b1, 5, 32'h5);
    cycle(1'b1, 5, 5, 1'b1, 5, 32'h00414020);
    want = BYP ? 32'h00414020 : 32'h5;
    checks++; if (bus.data_r1 !== want || bus.data_r2 !== want) $display("FAIL collision r1=%h r2=%h exp %h", bus.data_r1, bus.data_r2, want); else passed++;
    cycle(1'b1, 5, 4, 1'b0, 0, '0);
    checks++; if (bus.data_r1 !== 32'h00414020 || bus.data_r2 !== 32'h4) $display("FAIL after_collision r1=%h r2=%h exp 00414020 4", bus.data_r1, bus.data_r2); else passed++;
  endtask

  task automatic test_hold();
    cycle(1'b1, 9, 10, 1'b0, 0, '0);
    checks++; if (bus.data_r1 !== 32'h9 || bus.data_r2 !== 32'hA || bus.rd_valid !== 1'b1) $display("FAIL hold_read r1=%h r2=%h v=%b exp 9 a 1", bus.data_r1, bus.data_r2, bus.rd_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 20, 21, 1'b1, 9, DW'($urandom));
      checks++; if (bus.data_r1 !== 32'h9 || bus.data_r2 !== 32'hA || bus.rd_valid !== 1'b0) $display("FAIL hold_idle i=%0d r1=%h r2=%h v=%b exp 9 a 0", i, bus.data_r1, bus.data_r2, bus.rd_valid); else passed++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bit rd, wr;
      int a1, a2, wa;
      rd = 1'($urandom);
      wr = 1'($urandom);
      a1 = int'($urandom_range(0, (n % 2) ? 7 : DEPTH-1));
      a2 = int'($urandom_range(0, (n % 2) ? 7 : DEPTH-1));
      wa = int'($urandom_range(0, (n % 2) ? 7 : DEPTH-1));
      cycle(rd, a1, a2, wr, wa, DW'($urandom));
      checks++; if (bus.data_r1 !== exp_r1 || bus.data_r2 !== exp_r2 || bus.rd_valid !== exp_v) $display("FAIL random n=%0d r1=%h r2=%h v=%b exp %h %h %b", n, bus.data_r1, bus.data_r2, bus.rd_valid, exp_r1, exp_r2, exp_v); else passed++;
    end
  endtask

  task automatic test_mid_clear();
    int cnt;
    cycle(1'b0, 0, 0, 1'b1, 12, 32'hCAFE0012);
    cycle(1'b1, 12, 12, 1'b0, 0, '0);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0 || bus.data_r1 !== '0) $display("FAIL async_reset busy=%b v=%b r1=%h exp 1 0 0", bus.busy, bus.rd_valid, bus.data_r1); else passed++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.busy !== 1'b1) $display("FAIL early_clear i=%0d busy=%b exp=1", i, bus.busy); else passed++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      bus.read = 1'b1;
      bus.write = 1'b1;
      bus.addr_r1 = AW'($urandom);
      bus.addr_r2 = AW'($urandom);
      bus.addr_w = AW'($urandom);
      bus.data_w = DW'($urandom) | 32'h1;
      step();
      cnt++;
      checks++; if (bus.rd_valid !== 1'b0) $display("FAIL busy_read cycle=%0d v=%b exp=0", cnt, bus.rd_valid); else passed++;
    end
    bus.read = 1'b0;
    bus.write = 1'b0;
    checks++; if (cnt !== DEPTH) $display("FAIL restart_len got=%0d exp=%0d", cnt, DEPTH); else passed++;
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, i, i, 1'b0, 0, '0);
      checks++; if (bus.data_r1 !== '0 || bus.data_r2 !== '0) $display("FAIL busy_write_leak a=%0d r1=%h r2=%h exp 0", i, bus.data_r1, bus.data_r2); else passed++;
    end
  endtask

  task automatic test_small();
    int cnt;
    rst_s = 1'b0;
    cnt = 0;
    while (sbus.busy === 1'b1 && cnt < 50) begin
      step();
      cnt++;
    end
    checks++; if (cnt !== 8) $display("FAIL small_clear_len got=%0d exp=8", cnt); else passed++;
    sbus.write = 1'b1; sbus.addr_w = 3'd7; sbus.data_w = 16'hA5A5;
    step();
    sbus.write = 1'b0;
    sbus.read = 1'b1; sbus.addr_r1 = 3'd7; sbus.addr_r2 = 3'd6;
    step();
    sbus.read = 1'b0;
    checks++; if (sbus.data_r1 !== 16'hA5A5 || sbus.data_r2 !== 16'h0 || sbus.rd_valid !== 1'b1) $display("FAIL small_read r1=%h r2=%h v=%b exp a5a5 0 1", sbus.data_r1, sbus.data_r2, sbus.rd_valid); else passed++;
    sbus.addr_r1 = 3'd1; sbus.addr_r2 = 3'd2;
    step();
    checks++; if (sbus.data_r1 !== 16'hA5A5 || sbus.rd_valid !== 1'b0) $display("FAIL small_hold r1=%h v=%b exp a5a5 0", sbus.data_r1, sbus.rd_valid); else passed++;
    sbus.write = 1'b1; sbus.addr_w = 3'd0; sbus.data_w = 16'h1234;
    step();
    sbus.write = 1'b0;
    sbus.read = 1'b1; sbus.addr_r1 = 3'd0; sbus.addr_r2 = 3'd0;
    step();
    sbus.read = 1'b0;
    checks++; if (sbus.data_r1 !== 16'h1234 || sbus.data_r2 !== 16'h1234) $display("FAIL small_entry0 r1=%h r2=%h exp 1234", sbus.data_r1, sbus.data_r2); else passed++;
  endtask

  initial begin
    bus.read = 1'b0; bus.write = 1'b0; bus.addr_r1 = '0; bus.addr_r2 = '0; bus.addr_w = '0; bus.data_w = '0;
    sbus.read = 1'b0; sbus.write = 1'b0; sbus.addr_r1 = '0; sbus.addr_r2 = '0; sbus.addr_w = '0; sbus.data_w = '0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_collision();
    test_hold();
    test_random();
    test_mid_clear();
    test_small();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
